// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, multi-cycle mul/div
// occupancy of EX, and wrong-path squash. Optional perf counters under STALL_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W    = 5,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_muldiv,
  input  logic                  ex_branch_taken,
  output logic                  pc_hold,
  output logic                  ifid_hold,
  output logic                  idex_hold,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  busy,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
);

  localparam int CNT_W = $clog2(MULDIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 2);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = ex_is_load && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    busy        = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (ex_muldiv) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_hold   = 1'b1;
            exmem_flush = 1'b1;
            state_d     = MD_WAIT;
            cnt_d       = CNT_LOAD;
          end else if (load_use) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          busy = 1'b1;
          // The final cycle releases the pipeline so the op advances to MEM.
          if (cnt_q != '0) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_hold   = 1'b1;
            exmem_flush = 1'b1;
            cnt_d       = cnt_q - CNT_W'(1);
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (pc_hold)    perf_stall_q <= perf_stall_q + 32'd1;
      if (ifid_flush) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (MULDIV_CYCLES=4 and 2) against a cycle-age model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_is_load, ex_muldiv, ex_branch_taken;

  logic pc_hold_a, ifid_hold_a, idex_hold_a, ifid_flush_a, idex_flush_a, exmem_flush_a, busy_a;
  logic pc_hold_b, ifid_hold_b, idex_hold_b, ifid_flush_b, idex_flush_b, exmem_flush_b, busy_b;
  logic [31:0] perf_stall_a, perf_flush_a, perf_stall_b, perf_flush_b;

  int total = 0;
  int bad   = 0;

`ifdef STALL_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .MULDIV_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_muldiv(ex_muldiv), .ex_branch_taken(ex_branch_taken),
    .pc_hold(pc_hold_a), .ifid_hold(ifid_hold_a), .idex_hold(idex_hold_a),
    .ifid_flush(ifid_flush_a), .idex_flush(idex_flush_a), .exmem_flush(exmem_flush_a),
    .busy(busy_a), .perf_stall_cnt(perf_stall_a), .perf_flush_cnt(perf_flush_a)
  );

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .MULDIV_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_muldiv(ex_muldiv), .ex_branch_taken(ex_branch_taken),
    .pc_hold(pc_hold_b), .ifid_hold(ifid_hold_b), .idex_hold(idex_hold_b),
    .ifid_flush(ifid_flush_b), .idex_flush(idex_flush_b), .exmem_flush(exmem_flush_b),
    .busy(busy_b), .perf_stall_cnt(perf_stall_b), .perf_flush_cnt(perf_flush_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // age = cycles since a mul/div op entered EX (-1 when none in EX).
  // Returned vector: {pc_hold, ifid_hold, idex_hold, ifid_flush, idex_flush, exmem_flush, busy}
  function automatic logic [6:0] model(input int m, input int age, output int nage);
    logic lu;
    lu = ex_is_load && (ex_rd != 5'd0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    nage = -1;
    if (rst) return 7'b0;
    if (age >= 1) begin
      nage = (age >= m - 1) ? -1 : age + 1;
      return (age <= m - 2) ? 7'b1110011 : 7'b0000001;
    end
    if (ex_branch_taken) return 7'b0001100;
    if (ex_muldiv) begin
      nage = 1;
      return 7'b1110010;
    end
    if (lu) return 7'b1100100;
    return 7'b0;
  endfunction

  int          age_a = -1, age_b = -1;
  logic [31:0] es_a = 0, ef_a = 0, es_b = 0, ef_b = 0;

  always @(negedge clk) begin
    logic [6:0] ea, eb;
    int na, nb;
    ea = model(4, age_a, na);
    eb = model(2, age_b, nb);
    check("outs_a", {25'd0, pc_hold_a, ifid_hold_a, idex_hold_a, ifid_flush_a,
                     idex_flush_a, exmem_flush_a, busy_a}, {25'd0, ea});
    check("outs_b", {25'd0, pc_hold_b, ifid_hold_b, idex_hold_b, ifid_flush_b,
                     idex_flush_b, exmem_flush_b, busy_b}, {25'd0, eb});
    check("perf_stall_a", perf_stall_a, PERF_ON ? es_a : 32'd0);
    check("perf_flush_a", perf_flush_a, PERF_ON ? ef_a : 32'd0);
    check("perf_stall_b", perf_stall_b, PERF_ON ? es_b : 32'd0);
    check("perf_flush_b", perf_flush_b, PERF_ON ? ef_b : 32'd0);
    age_a = na;
    age_b = nb;
    if (rst) begin
      es_a = 0; ef_a = 0; es_b = 0; ef_b = 0;
    end else begin
      es_a = es_a + {31'd0, ea[6]};
      ef_a = ef_a + {31'd0, ea[3]};
      es_b = es_b + {31'd0, eb[6]};
      ef_b = ef_b + {31'd0, eb[3]};
    end
  end

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_is_load = 1'b0; ex_muldiv = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_is_load = 1'b1; ex_rd = rd; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
  endtask

  initial begin
    logic [3:0] hold_a_tbl, busy_a_tbl, hold_b_tbl, busy_b_tbl;
    hold_a_tbl = 4'b0111;  // index i = cycle i of a held ex_muldiv
    busy_a_tbl = 4'b1110;
    hold_b_tbl = 4'b0101;
    busy_b_tbl = 4'b1010;

    rst = 1'b1;
    idle();
    repeat (2) tick();
    @(negedge clk);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_pc_hold", {31'd0, pc_hold_a}, 32'd0);

    // load-use on rs2
    tick(); rst = 1'b0; set_load_use(5'd5);
    @(negedge clk);
    check("lu_pc_hold", {31'd0, pc_hold_a}, 32'd1);
    check("lu_ifid_hold", {31'd0, ifid_hold_a}, 32'd1);
    check("lu_idex_flush", {31'd0, idex_flush_a}, 32'd1);
    check("lu_idex_hold", {31'd0, idex_hold_a}, 32'd0);
    tick(); idle();
    @(negedge clk);
    check("lu_clear", {31'd0, pc_hold_a}, 32'd0);
    tick(); set_load_use(5'd0); id_rs2 = 5'd0;
    @(negedge clk);
    check("lu_r0_pc_hold", {31'd0, pc_hold_a}, 32'd0);
    check("lu_r0_idex_flush", {31'd0, idex_flush_a}, 32'd0);

    // ex_muldiv held for four cycles
    for (int i = 0; i < 4; i++) begin
      tick(); idle(); ex_muldiv = 1'b1;
      @(negedge clk);
      check($sformatf("md4_hold%0d", i), {31'd0, pc_hold_a}, {31'd0, hold_a_tbl[i]});
      check($sformatf("md4_exmem%0d", i), {31'd0, exmem_flush_a}, {31'd0, hold_a_tbl[i]});
      check($sformatf("md4_busy%0d", i), {31'd0, busy_a}, {31'd0, busy_a_tbl[i]});
      check($sformatf("md2_hold%0d", i), {31'd0, idex_hold_b}, {31'd0, hold_b_tbl[i]});
      check($sformatf("md2_busy%0d", i), {31'd0, busy_b}, {31'd0, busy_b_tbl[i]});
    end
    tick(); idle();
    @(negedge clk);
    check("md4_done_busy", {31'd0, busy_a}, 32'd0);
    check("md4_done_hold", {31'd0, pc_hold_a}, 32'd0);

    // taken branch, alone and against a load-use match
    tick(); ex_branch_taken = 1'b1;
    @(negedge clk);
    check("br_ifid_flush", {31'd0, ifid_flush_a}, 32'd1);
    check("br_idex_flush", {31'd0, idex_flush_a}, 32'd1);
    check("br_pc_hold", {31'd0, pc_hold_a}, 32'd0);
    tick(); set_load_use(5'd5);
    @(negedge clk);
    check("brlu_ifid_flush", {31'd0, ifid_flush_a}, 32'd1);
    check("brlu_pc_hold", {31'd0, pc_hold_a}, 32'd0);
    check("brlu_ifid_hold", {31'd0, ifid_hold_a}, 32'd0);

    // reset in the middle of a mul/div wait
    tick(); idle(); ex_muldiv = 1'b1;
    tick(); ex_muldiv = 1'b0;
    @(negedge clk);
    check("mdrst_busy_before", {31'd0, busy_a}, 32'd1);
    tick(); rst = 1'b1;
    @(negedge clk);
    check("mdrst_in_rst", {31'd0, pc_hold_a}, 32'd0);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("mdrst_busy", {31'd0, busy_a}, 32'd0);
    check("mdrst_holds", {29'd0, pc_hold_a, ifid_hold_a, idex_hold_a}, 32'd0);
    tick();
    @(negedge clk);
    check("mdrst_stays", {30'd0, busy_a, pc_hold_a}, 32'd0);

    // perf counters over load-use + mul/div + branch
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; set_load_use(5'd5);
    tick(); idle();
    tick(); ex_muldiv = 1'b1;
    tick(); idle();
    tick();
    tick();
    tick(); ex_branch_taken = 1'b1;
    tick(); idle();
    @(negedge clk);
    check("perf_stall_lit", perf_stall_a, PERF_ON ? 32'd4 : 32'd0);
    check("perf_flush_lit", perf_flush_a, PERF_ON ? 32'd1 : 32'd0);

    // randomized traffic, checked cycle by cycle by the model
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst             = ($urandom_range(0, 99) == 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_use_rs1      = 1'($urandom_range(0, 1));
      id_use_rs2      = 1'($urandom_range(0, 1));
      ex_is_load      = ($urandom_range(0, 2) == 0);
      ex_muldiv       = ($urandom_range(0, 7) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
    end
    tick(); idle(); rst = 1'b0;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
